// File: rtl/cache_control.sv
// Control FSM for a 4-way set-associative write-back/write-allocate cache.
// Owns per-set valid, dirty and tree-PLRU state; drives the datapath and pmem handshake.
module cache_control #(
   parameter int s_offset = 5,
   parameter int s_index  = 4,
   parameter int num_sets = 2**s_index
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_addr,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic        mem_resp,
   input  logic [3:0]  tag_match,
   output logic [1:0]  way_sel,
   output logic [3:0]  data_we,
   output logic [3:0]  tag_we,
   output logic        data_src,
   output logic        addr_sel,
   output logic        pmem_read,
   output logic        pmem_write,
   input  logic        pmem_resp
);
   typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, REFETCH} state_t;

   state_t state, state_nx;
   logic [num_sets-1:0][3:0] valid, dirty;
   logic [num_sets-1:0][2:0] plru;
   logic [s_index-1:0]       idx;
   logic [3:0]               hit;
   logic [1:0]               hit_way, vict, vict_q;
   logic                     is_hit, req;
   logic                     unused_ok;

   assign idx       = mem_addr[s_offset +: s_index];
   assign hit       = tag_match & valid[idx];
   assign is_hit    = |hit;
   assign req       = mem_read | mem_write;
   assign unused_ok = ^{mem_addr[31:s_offset+s_index], mem_addr[s_offset-1:0]};

   always_comb begin
      hit_way = 2'd0;
      for (int w = 3; w >= 0; w--)
         if (hit[w]) hit_way = 2'(w);
   end

   // Fill empty ways lowest-first; only consult PLRU once the set is full.
   always_comb begin
      if (&valid[idx]) begin
         if (plru[idx][0]) vict = plru[idx][2] ? 2'd3 : 2'd2;
         else              vict = plru[idx][1] ? 2'd1 : 2'd0;
      end else begin
         vict = 2'd0;
         for (int w = 3; w >= 0; w--)
            if (!valid[idx][w]) vict = 2'(w);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         vict_q <= 2'd0;
      end else begin
         state <= state_nx;
         if (state == COMPARE && !is_hit) vict_q <= vict;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         dirty <= '0;
         plru  <= '0;
      end else if (state == COMPARE && is_hit) begin
         case (hit_way)
            2'd0: begin plru[idx][0] <= 1'b1; plru[idx][1] <= 1'b1; end
            2'd1: begin plru[idx][0] <= 1'b1; plru[idx][1] <= 1'b0; end
            2'd2: begin plru[idx][0] <= 1'b0; plru[idx][2] <= 1'b1; end
            default: begin plru[idx][0] <= 1'b0; plru[idx][2] <= 1'b0; end
         endcase
         if (mem_write) dirty[idx][hit_way] <= 1'b1;
      end else if (state == ALLOCATE && pmem_resp) begin
         valid[idx][vict_q] <= 1'b1;
         dirty[idx][vict_q] <= 1'b0;
      end
   end

   always_comb begin
      state_nx   = state;
      mem_resp   = 1'b0;
      way_sel    = 2'd0;
      data_we    = 4'd0;
      tag_we     = 4'd0;
      data_src   = 1'b0;
      addr_sel   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      case (state)
         IDLE: if (req) state_nx = COMPARE;
         COMPARE: begin
            if (is_hit) begin
               mem_resp = 1'b1;
               way_sel  = hit_way;
               if (mem_write) data_we = 4'd1 << hit_way;
               state_nx = IDLE;
            end else begin
               way_sel  = vict;
               state_nx = (valid[idx][vict] & dirty[idx][vict]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            pmem_write = 1'b1;
            addr_sel   = 1'b1;
            way_sel    = vict_q;
            if (pmem_resp) state_nx = ALLOCATE;
         end
         ALLOCATE: begin
            pmem_read = 1'b1;
            way_sel   = vict_q;
            if (pmem_resp) begin
               data_we  = 4'd1 << vict_q;
               tag_we   = 4'd1 << vict_q;
               data_src = 1'b1;
               state_nx = REFETCH;
            end
         end
         REFETCH: state_nx = COMPARE;
         default: state_nx = IDLE;
      endcase
   end

   // Tag arrays must never hold the same tag in two valid ways of one set.
   a_onehot_hit: assert property (@(posedge clk) disable iff (!rst_n)
      (state == COMPARE) |-> $onehot0(hit));
endmodule

// File: tb/tb_cache_control.sv
// Directed + model-driven bench for cache_control: vector table, dirty/PLRU
// corner sequences, async reset mid-writeback and a random-latency set sweep.
module tb_cache_control;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] mem_addr = '0;
   logic        mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
   logic [3:0]  tag_match = '0;
   logic        mem_resp, data_src, addr_sel, pmem_read, pmem_write;
   logic [1:0]  way_sel;
   logic [3:0]  data_we, tag_we;

   int checks = 0, fails = 0, resp_seen = 0, exp_resps = 0;
   bit prev_resp = 1'b0;

   cache_control dut (
      .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_write(mem_write), .mem_resp(mem_resp), .tag_match(tag_match),
      .way_sel(way_sel), .data_we(data_we), .tag_we(tag_we), .data_src(data_src),
      .addr_sel(addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Per-cycle protocol monitor, sampled well after inputs settle.
   initial forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         chk("rd_wr_both", {31'd0, pmem_read & pmem_write}, 32'd0);
         chk("resp_consecutive", {31'd0, mem_resp & prev_resp}, 32'd0);
         prev_resp = mem_resp;
         if (mem_resp) resp_seen++;
      end else prev_resp = 1'b0;
   end

   a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      ((mem_read || mem_write) && !mem_resp) |=> (mem_read || mem_write));

   task automatic chk_idle_outputs(input string nm);
      chk({nm, ".resp"}, mem_resp, 0);
      chk({nm, ".pmem"}, {pmem_read, pmem_write}, 0);
      chk({nm, ".we"}, {data_we, tag_we}, 0);
      chk({nm, ".sel"}, {way_sel, addr_sel, data_src}, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; tag_match = '0; pmem_resp = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_resp(input string nm, input bit wr, input logic [1:0] w);
      chk({nm, ".resp"}, mem_resp, 1);
      chk({nm, ".way"}, way_sel, w);
      chk({nm, ".data_we"}, data_we, wr ? (32'd1 << w) : 32'd0);
      chk({nm, ".tag_we"}, tag_we, 0);
      if (wr) chk({nm, ".src"}, data_src, 0);
      exp_resps++;
   endtask

   // One CPU transaction; starts at a posedge+1, ends on a negedge.
   task automatic do_txn(input bit rd, input bit wr, input logic [3:0] idx, input logic [3:0] tm,
                         input bit exp_hit, input logic [1:0] ew, input bit exp_wb,
                         input int lat, input string nm);
      @(posedge clk); #1;
      mem_addr  = {23'($urandom), idx, 5'($urandom)};
      mem_read  = rd; mem_write = wr; tag_match = tm;
      @(posedge clk); @(negedge clk);
      if (exp_hit) check_resp(nm, wr, ew);
      else begin
         chk({nm, ".miss_resp"}, mem_resp, 0);
         chk({nm, ".victim"}, way_sel, ew);
         @(posedge clk); @(negedge clk);
         if (exp_wb) begin
            chk({nm, ".wb"}, {pmem_write, pmem_read, addr_sel, way_sel}, {29'd0, 3'b101, ew});
            repeat (lat) begin
               @(posedge clk); @(negedge clk);
               chk({nm, ".wb_hold"}, pmem_write, 1);
            end
            pmem_resp = 1'b1;
            @(posedge clk); #1 pmem_resp = 1'b0;
            @(negedge clk);
         end
         chk({nm, ".alloc"}, {pmem_read, pmem_write, addr_sel}, 3'b100);
         repeat (lat) begin
            @(posedge clk); @(negedge clk);
            chk({nm, ".rd_hold"}, {pmem_read, data_we}, {1'b1, 4'd0});
         end
         pmem_resp = 1'b1;
         #1;
         chk({nm, ".fill_we"}, {data_we, tag_we}, {4'd1 << ew, 4'd1 << ew});
         chk({nm, ".fill_src"}, data_src, 1);
         @(posedge clk); #1;
         pmem_resp = 1'b0; tag_match = 4'd1 << ew;
         @(negedge clk);
         chk({nm, ".refetch"}, {mem_resp, pmem_read, data_we}, 0);
         @(posedge clk); @(negedge clk);
         check_resp({nm, ".after_fill"}, wr, ew);
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; tag_match = '0;
      @(negedge clk);
      chk({nm, ".resp_drop"}, mem_resp, 0);
   endtask

   typedef struct {
      bit rd, wr;
      logic [3:0] idx, tm;
      bit hit;
      logic [1:0] way;
      bit wb;
      int lat;
   } vec_t;
   vec_t vt[22];

   bit mv[16][4], md[16][4];
   bit [2:0] mp[16];

   function automatic logic [1:0] m_victim(input int s);
      for (int w = 0; w < 4; w++) if (!mv[s][w]) return 2'(w);
      if (mp[s][0]) return mp[s][2] ? 2'd3 : 2'd2;
      return mp[s][1] ? 2'd1 : 2'd0;
   endfunction

   initial begin
      // Set 2 access story; expected victims/writebacks worked out by hand.
      vt[0]  = '{1,0,2,4'b0000,0,0,0,2};  // cold miss -> way0
      vt[1]  = '{1,0,2,4'b0001,1,0,0,0};  // read hit way0
      vt[2]  = '{1,0,2,4'b0000,0,1,0,0};
      vt[3]  = '{1,0,2,4'b0000,0,2,0,1};
      vt[4]  = '{1,0,2,4'b0000,0,3,0,4};  // set full, plru b0=0 b2=0
      vt[5]  = '{1,1,2,4'b0010,1,1,0,0};  // read+write = write hit way1 (dirty)
      vt[6]  = '{1,0,2,4'b0000,0,2,0,1};  // plru picks way2, clean
      vt[7]  = '{0,1,2,4'b1000,1,3,0,0};  // dirty way3
      vt[8]  = '{1,0,2,4'b0100,1,2,0,0};
      vt[9]  = '{1,0,2,4'b0001,1,0,0,0};  // b0=1 b2=1 -> victim way3
      vt[10] = '{1,0,2,4'b0000,0,3,1,3};  // dirty miss, writeback way3
      vt[11] = '{1,0,2,4'b0000,0,1,1,0};  // way1 still dirty
      vt[12] = '{1,0,2,4'b0100,1,2,0,0};
      vt[13] = '{1,0,2,4'b0001,1,0,0,0};
      vt[14] = '{0,1,2,4'b0000,0,3,0,2};  // way3 clean after read refill; write miss dirties it
      vt[15] = '{1,0,2,4'b0100,1,2,0,0};
      vt[16] = '{1,0,2,4'b0001,1,0,0,0};
      vt[17] = '{1,0,2,4'b0000,0,3,1,1};  // write-miss line is dirty
      vt[18] = '{0,1,2,4'b0010,1,1,0,0};
      vt[19] = '{1,0,2,4'b0001,1,0,0,0};
      vt[20] = '{1,0,2,4'b1000,1,3,0,0};  // victim now dirty way1
      vt[21] = '{1,0,5,4'b1111,0,0,0,0};  // raw matches on invalid ways still miss

      do_reset();
      foreach (vt[k])
         do_txn(vt[k].rd, vt[k].wr, vt[k].idx, vt[k].tm, vt[k].hit, vt[k].way,
                vt[k].wb, vt[k].lat, $sformatf("vec%0d", k));

      // Async reset in the middle of a writeback of way1.
      @(posedge clk); #1;
      mem_addr = {23'd7, 4'd2, 5'd0}; mem_read = 1'b1; tag_match = '0;
      @(posedge clk); @(negedge clk);
      chk("rstwb.victim", way_sel, 1);
      @(posedge clk); @(negedge clk);
      chk("rstwb.wb", {pmem_write, addr_sel, way_sel}, {2'b11, 2'd1});
      #1 rst_n = 1'b0;
      #1 chk_idle_outputs("rstwb.async");
      @(posedge clk); #1 mem_read = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("rstwb.idle");
      do_txn(1, 0, 2, 4'b0001, 0, 0, 0, 2, "rstwb.cleared");

      // Model-checked sweep over all sets with random pmem latency.
      do_reset();
      foreach (mv[s, w]) begin mv[s][w] = 0; md[s][w] = 0; end
      foreach (mp[s]) mp[s] = 3'd0;
      for (int pass = 0; pass < 6; pass++) begin
         for (int s = 0; s < 16; s++) begin
            bit wr, h;
            logic [3:0] vm, junk, tm;
            logic [1:0] ew;
            bit wb;
            int w;
            wr = (pass == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            vm = {mv[s][3], mv[s][2], mv[s][1], mv[s][0]};
            junk = 4'($urandom) & ~vm;
            h = (vm != 0) && ($urandom_range(0, 1) == 1);
            if (h) begin
               w = $urandom_range(0, 3);
               while (!mv[s][w]) w = (w + 1) % 4;
               ew = 2'(w); tm = (4'd1 << w) | junk; wb = 1'b0;
            end else begin
               ew = m_victim(s); tm = junk; wb = mv[s][ew] & md[s][ew];
            end
            do_txn(1'b1, wr, 4'(s), tm, h, ew, wb, $urandom_range(0, 10),
                   $sformatf("rnd%0d_%0d", pass, s));
            if (!h) begin mv[s][ew] = 1; md[s][ew] = 0; end
            if (wr) md[s][ew] = 1;
            case (ew)
               2'd0: begin mp[s][0] = 1; mp[s][1] = 1; end
               2'd1: begin mp[s][0] = 1; mp[s][1] = 0; end
               2'd2: begin mp[s][0] = 0; mp[s][2] = 1; end
               default: begin mp[s][0] = 0; mp[s][2] = 0; end
            endcase
         end
      end

      #5;
      chk("resp_count", resp_seen, exp_resps);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end
endmodule
